// File: rtl/avalon_pkg.sv
// Shared types and constants for the wait-state-stretching Avalon-MM RAM responder.
package avalon_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam int          WORD_BYTES = 4;
  // Taps 8,6,5,4 of an 8-bit Fibonacci LFSR, as a mask over bits [7:0].
  localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
  localparam logic [31:0] ERR_RDATA  = 32'h0;

  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/avalon_stall_ram_if.sv
// Avalon-MM word bus between a master and the stalling RAM responder.
interface avalon_stall_ram_if;

  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata
  );

endinterface

// File: rtl/stall_lfsr.sv
// 8-bit Fibonacci LFSR that advances once per accepted request; its low nibble
// is the wait-state count in random mode.
module stall_lfsr
  import avalon_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       adv_i,
  output logic [3:0] wait_o
);

  logic [7:0] lfsr_q, lfsr_d;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) lfsr_d = lfsr_step(lfsr_q);
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign wait_o = lfsr_q[3:0];

endmodule

// File: rtl/avalon_stall_ram.sv
// Avalon-MM slave word RAM with fixed or LFSR-driven wait states, byte-enabled
// writes, a sticky protocol-error flag and a backdoor preload port.
module avalon_stall_ram
  import avalon_pkg::*;
#(
  parameter int          MEM_WORDS   = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                clk,
  input  logic                reset,
  avalon_stall_ram_if.slave   bus,
  input  logic                load_en,
  input  logic [31:0]         load_addr,
  input  logic [31:0]         load_data,
  output logic                bus_err
);

  localparam int          IDX_W = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN  = 32'(WORD_BYTES * MEM_WORDS);

  typedef logic [IDX_W-1:0] idx_t;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  idx_t        idx_q, idx_d;
  logic        drop_q, drop_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req;
  logic        waitreq;
  logic        commit;
  logic [3:0]  lfsr_wait;
  logic [31:0] bus_off, ld_off;
  logic        bus_ok, ld_ok;
  idx_t        bus_idx, ld_idx;

  logic [31:0] mem [MEM_WORDS];

  // Unsigned offset wraps to a huge value below BASE_ADDR, so one compare covers both bounds.
  assign bus_off = bus.address - BASE_ADDR;
  assign bus_ok  = (bus_off < SPAN) && (bus.address[1:0] == 2'b00);
  assign bus_idx = bus_off[IDX_W+1:2];
  assign ld_off  = load_addr - BASE_ADDR;
  assign ld_ok   = (ld_off < SPAN) && (load_addr[1:0] == 2'b00);
  assign ld_idx  = ld_off[IDX_W+1:2];

  assign req = bus.read | bus.write;

  stall_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .adv_i  ((state_q == S_IDLE) && req),
    .wait_o (lfsr_wait)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    waitreq = 1'b1;
    commit  = 1'b0;

    case (state_q)
      S_IDLE: begin
        waitreq = req;
        if (req) begin
          addr_d  = bus.address;
          rd_d    = bus.read;
          wr_d    = bus.write;
          be_d    = bus.byteenable;
          wdata_d = bus.writedata;
          idx_d   = bus_idx;
          drop_d  = !bus_ok;
          cnt_d   = RANDOM_WAIT ? lfsr_wait : 4'(WAIT_CYCLES);
          if (!bus_ok || (bus.read && bus.write)) err_d = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        // A master that moves its request mid-stall is flagged; the latched copy still completes.
        if ({bus.read, bus.write, bus.address} != {rd_q, wr_q, addr_q}) err_d = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          if (rd_q) rdata_d = drop_q ? ERR_RDATA : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        waitreq = 1'b0;
        // A simultaneous read+write was executed as a read, so it never commits.
        commit  = wr_q && !rd_q && !drop_q && !reset;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (reset) waitreq = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      idx_q   <= '0;
      drop_q  <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: memory contents are deliberately not reset; test programs preload them through the backdoor.
  // The bus lanes are assigned after the backdoor word, so a same-cycle bus write wins.
  always_ff @(posedge clk) begin
    if (load_en && ld_ok) mem[ld_idx] <= load_data;
    if (commit) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign bus.waitrequest = waitreq;
  assign bus.readdata    = rdata_q;
  assign bus_err         = err_q;

endmodule

// File: doc/avalon_stall_ram.md
# avalon_stall_ram

Avalon-MM slave word memory that answers the CPU's bus master (`address`/`read`/`write`/`waitrequest`/`byteenable`) with a controllable number of wait states. It is the simulation responder used to stress the CPU's stall handling: fixed or pseudo-random `waitrequest` stretching, byte-enabled writes, a sticky protocol-error flag, and a backdoor preload port for test programs. It sits beside `top_level_cpu` in bench top levels in place of the zero-frills RAM.

## Interface
Parameters:
- `MEM_WORDS`, 256: depth in 32-bit words (power of two)
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0
- `WAIT_CYCLES`, 0: extra wait states per transaction in fixed mode (0..15)
- `RANDOM_WAIT`, 0: 1 = wait states taken from LFSR
- `LFSR_SEED`, 8'hA5: nonzero LFSR reset value

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock
- `reset` in 1: synchronous, active-high
- `address` in 32: byte address from master
- `read` in 1: read request
- `write` in 1: write request
- `byteenable` in 4: lane enables, bit n = `writedata[8n+7:8n]`
- `writedata` in 32: write data
- `waitrequest` out 1: slave stall
- `readdata` out 32: read data, valid in ACK cycle of a read
- `load_en` in 1: backdoor write strobe
- `load_addr` in 32: backdoor byte address
- `load_data` in 32: backdoor full-word data
- `bus_err` out 1: sticky protocol/address error

## Operation
- FSM states IDLE, WAIT, ACK.
- IDLE: `waitrequest` = `read|write` (combinational). On request: latch address, op, byteenable, writedata; load `cnt` with wait count; go WAIT.
- WAIT: `waitrequest`=1. If `cnt`==0 go ACK, else decrement.
- ACK: `waitrequest`=0; `readdata` holds word registered on WAIT→ACK edge. Write committed on the clock edge ending ACK, only enabled lanes. Next state IDLE unconditionally (back-to-back requests re-enter WAIT from IDLE).
- Wait count: fixed mode `WAIT_CYCLES`; random mode `lfsr[3:0]`. LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances once per accepted request.
- Word index = `(address-BASE_ADDR)>>2`.
- Errors (set `bus_err`, cleared only by reset): address outside `[BASE_ADDR, BASE_ADDR+4*MEM_WORDS)` → read returns 0, write dropped; `address[1:0]`≠0 → same; `read&write` both high → executed as read; `read`/`write`/`address` changed while in WAIT → transaction completes on latched values.
- `byteenable`=0 on a write: legal, no change.
- Backdoor: `load_en` writes full word at clock edge, any state. Same word as an ACK-cycle bus write in same cycle → bus write wins. Out-of-range/misaligned loads ignored, no `bus_err`.

## Timing
- Reset (while high and following edge): state IDLE, `cnt`=0, LFSR=`LFSR_SEED`, `readdata`=0, `bus_err`=0, `waitrequest`=1. Memory contents not cleared.
- Latency: request seen in cycle 0; ACK in cycle `2+W` (W = wait count); `waitrequest` high for `2+W` cycles, low for exactly one.
- `readdata` changes only on WAIT→ACK edge; holds until next read's ACK.
- Reset mid-transaction: aborted; pending write not committed.
- Read following write to same word: sees new data (write committed before next WAIT).

## Structure
- Shared package `avalon_pkg`: FSM state enum, `WORD_BYTES`=4, LFSR tap constant, error-read value 32'h0.
- Optional sub-module `stall_lfsr` (8-bit LFSR with advance enable, seed parameter); otherwise single module.

## Test plan
- Fixed `WAIT_CYCLES`=0: backdoor 32'h3C02FCFC at 0x04, read 0x04 → `waitrequest` high 2 cycles, ACK cycle `readdata`=32'h3C02FCFC.
- `WAIT_CYCLES`=3: write 32'hDEADBEEF to 0x10, byteenable 4'b0101 over preloaded 0 → read back 32'h00AD00EF; each transaction stalls 5 cycles.
- Read 0x1000 with `MEM_WORDS`=256 → `readdata`=0, `bus_err`=1 and stays 1 through further valid reads until reset.
- `RANDOM_WAIT`=1, seed 8'hA5: 20 back-to-back reads → stall lengths match reference LFSR model, all data correct.
- Reset asserted during WAIT of write 32'h12345678 to 0x08 → word 0x08 unchanged, `readdata`=0, `waitrequest`=1 during reset.
- `read`&`write` both high at 0x04 → treated as read, memory unchanged, `bus_err`=1.
